// File: rtl/buffer_level.sv
// rtl/buffer_level.sv - parameterised circular-buffer FIFO with level flags, skid and bypass options
//
// Ports:
//   clk          : single clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset (clears count and pointers)
//   srst         : synchronous active-high clear, blocks both handshakes while high
//   push_valid   : producer offers push_data
//   push_ready   : buffer accepts a beat this cycle
//   push_data    : write payload, WIDTH bits
//   pop_valid    : pop_data is valid
//   pop_ready    : consumer takes pop_data
//   pop_data     : read payload, WIDTH bits
//   count        : stored-entry count, $clog2(DEPTH+1) bits
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
module buffer_level #(
    parameter int WIDTH    = 1,
    parameter int DEPTH    = 4,
    parameter int SKID     = 0,
    parameter int BYPASS   = 0,
    parameter int AF_LEVEL = DEPTH,
    parameter int AE_LEVEL = 0,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty
);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("buffer_level: DEPTH must be >= 1");
        end
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
            $error("buffer_level: AF_LEVEL must be in 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
            $error("buffer_level: AE_LEVEL must be in 0..DEPTH-1");
        end
        if (SKID != 0 && SKID != 1) begin : g_bad_skid
            $error("buffer_level: SKID must be 0 or 1");
        end
        if (BYPASS != 0 && BYPASS != 1) begin : g_bad_bypass
            $error("buffer_level: BYPASS must be 0 or 1");
        end
    endgenerate

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] f_wrap_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_store;
    logic w_take;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // With SKID a full buffer still accepts when the consumer is draining;
    // a full buffer always has pop_valid high, so the pop is guaranteed.
    assign push_ready = !srst && (!w_full || ((SKID == 1) && pop_ready));
    assign pop_valid  = !srst && (!w_empty || ((BYPASS == 1) && push_valid));
    assign pop_data   = ((BYPASS == 1) && w_empty) ? push_data : r_mem[r_rptr];

    assign w_push = push_valid && push_ready;
    assign w_pop  = pop_valid && pop_ready;

    // A beat that flows straight through an empty buffer never touches storage.
    assign w_bypass = (BYPASS == 1) && w_empty && w_push && w_pop;
    assign w_store  = w_push && !w_bypass;
    assign w_take   = w_pop && !w_bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (srst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_wptr <= f_wrap_inc(r_wptr);
            end
            if (w_take) begin
                r_rptr <= f_wrap_inc(r_rptr);
            end
            if (w_store && !w_take) begin
                r_count <= r_count + 1'b1;
            end else if (w_take && !w_store) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_store && !srst) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    assign count        = r_count;
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_buffer_level.sv
// tb/tb_buffer_level.sv - self-checking bench for buffer_level across five parameter sets
module tb_buffer_level;

    localparam int N = 5;
    // u0: depth 3 skid; u1: depth 4 bypass; u2: depth 5 af4/ae1; u3: depth 1 plain; u4: depth 6 skid+bypass
    localparam int P_DEPTH [N] = '{3, 4, 5, 1, 6};
    localparam int P_SKID  [N] = '{1, 0, 0, 0, 1};
    localparam int P_BYP   [N] = '{0, 1, 0, 0, 1};
    localparam int P_AF    [N] = '{3, 4, 4, 1, 6};
    localparam int P_AE    [N] = '{0, 0, 1, 0, 0};

    logic clk;
    logic rst_n;
    logic [N-1:0]      in_srst;
    logic [N-1:0]      in_pv;
    logic [N-1:0]      in_ord;
    logic [7:0]        in_pd [N];
    logic [N-1:0]      out_prdy;
    logic [N-1:0]      out_ov;
    logic [N-1:0][7:0] out_od;
    logic [N-1:0][7:0] out_cnt;
    logic [N-1:0]      out_af;
    logic [N-1:0]      out_ae;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq [N][$];
    int pushed [N];
    int popped [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int CWG = $clog2(P_DEPTH[g] + 1);
            logic [CWG-1:0] w_cnt;
            logic [7:0]     w_od;
            logic           w_prdy;
            logic           w_ov;
            logic           w_af;
            logic           w_ae;
            buffer_level #(
                .WIDTH(8), .DEPTH(P_DEPTH[g]), .SKID(P_SKID[g]), .BYPASS(P_BYP[g]),
                .AF_LEVEL(P_AF[g]), .AE_LEVEL(P_AE[g])
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .srst(in_srst[g]),
                .push_valid(in_pv[g]), .push_ready(w_prdy), .push_data(in_pd[g]),
                .pop_valid(w_ov), .pop_ready(in_ord[g]), .pop_data(w_od),
                .count(w_cnt), .almost_full(w_af), .almost_empty(w_ae)
            );
            assign out_cnt[g]  = 8'(w_cnt);
            assign out_od[g]   = w_od;
            assign out_prdy[g] = w_prdy;
            assign out_ov[g]   = w_ov;
            assign out_af[g]   = w_af;
            assign out_ae[g]   = w_ae;
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Reference behaviour: a queue of stored beats plus the handshake rules.
    function automatic bit f_prdy(int k);
        return !in_srst[k] && ((mq[k].size() < P_DEPTH[k]) || (P_SKID[k] == 1 && in_ord[k]));
    endfunction

    function automatic bit f_ov(int k);
        return !in_srst[k] && ((mq[k].size() != 0) || (P_BYP[k] == 1 && in_pv[k]));
    endfunction

    function automatic logic [7:0] f_od(int k);
        return (mq[k].size() != 0) ? mq[k][0] : in_pd[k];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) mq[k].delete();
        end else begin
            for (int k = 0; k < N; k++) begin
                if (in_srst[k]) begin
                    mq[k].delete();
                end else begin
                    automatic bit do_push = in_pv[k] && f_prdy(k);
                    automatic bit do_pop  = f_ov(k) && in_ord[k];
                    // Push before pop: a bypassed beat enters and leaves in one step.
                    if (do_push) begin
                        mq[k].push_back(in_pd[k]);
                        pushed[k]++;
                    end
                    if (do_pop) begin
                        void'(mq[k].pop_front());
                        popped[k]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            chk("count", k, 32'(out_cnt[k]), 32'(mq[k].size()));
            chk("push_ready", k, 32'(out_prdy[k]), 32'(f_prdy(k)));
            chk("pop_valid", k, 32'(out_ov[k]), 32'(f_ov(k)));
            chk("almost_full", k, 32'(out_af[k]), 32'(mq[k].size() >= P_AF[k]));
            chk("almost_empty", k, 32'(out_ae[k]), 32'(mq[k].size() <= P_AE[k]));
            if (f_ov(k)) chk("pop_data", k, 32'(out_od[k]), 32'(f_od(k)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input int k, input logic [7:0] v);
        in_pv[k] = 1'b1;
        in_pd[k] = v;
        cyc();
        in_pv[k] = 1'b0;
    endtask

    logic [7:0] seq [4];
    logic [5:0] ae_tab;
    logic [5:0] af_tab;

    initial begin
        seq    = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        ae_tab = 6'b000011;
        af_tab = 6'b110000;
        for (int k = 0; k < N; k++) begin
            pushed[k] = 0;
            popped[k] = 0;
            in_pd[k]  = 8'h00;
        end
        rst_n   = 1'b0;
        in_srst = '0;
        in_pv   = '0;
        in_ord  = '0;
        in_pv[1] = 1'b1;
        in_pd[1] = 8'h33;
        #2;
        for (int k = 0; k < N; k++) begin
            chk("rst_count", k, 32'(out_cnt[k]), 0);
            chk("rst_push_ready", k, 32'(out_prdy[k]), 1);
            chk("rst_pop_valid", k, 32'(out_ov[k]), (k == 1) ? 1 : 0);
            chk("rst_almost_full", k, 32'(out_af[k]), 0);
            chk("rst_almost_empty", k, 32'(out_ae[k]), 1);
        end
        chk("rst_bypass_data", 1, 32'(out_od[1]), 32'h33);
        #10;
        rst_n    = 1'b1;
        in_pv[1] = 1'b0;

        // Depth-3 fill, hold, then drain in order.
        for (int i = 0; i < 3; i++) push_one(0, seq[i]);
        #1;
        chk("full_count", 0, 32'(out_cnt[0]), 3);
        chk("full_push_ready", 0, 32'(out_prdy[0]), 0);
        chk("full_almost_full", 0, 32'(out_af[0]), 1);
        in_ord[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_data", 0, 32'(out_od[0]), 32'(seq[i]));
            cyc();
        end
        in_ord[0] = 1'b0;
        #1;
        chk("drained_count", 0, 32'(out_cnt[0]), 0);

        // Skid: full buffer pushes and pops together.
        for (int i = 0; i < 3; i++) push_one(0, seq[i]);
        in_pv[0]  = 1'b1;
        in_pd[0]  = seq[3];
        in_ord[0] = 1'b1;
        #1;
        chk("skid_push_ready", 0, 32'(out_prdy[0]), 1);
        chk("skid_pop_data", 0, 32'(out_od[0]), 32'h0A);
        cyc();
        in_pv[0] = 1'b0;
        #1;
        chk("skid_count", 0, 32'(out_cnt[0]), 3);
        for (int i = 1; i < 4; i++) begin
            chk("skid_drain_data", 0, 32'(out_od[0]), 32'(seq[i]));
            cyc();
        end
        in_ord[0] = 1'b0;

        // Bypass on empty, then normal storage when not empty.
        in_pv[1]  = 1'b1;
        in_pd[1]  = 8'h05;
        in_ord[1] = 1'b1;
        #1;
        chk("byp_pop_valid", 1, 32'(out_ov[1]), 1);
        chk("byp_pop_data", 1, 32'(out_od[1]), 32'h05);
        cyc();
        in_pv[1]  = 1'b0;
        in_ord[1] = 1'b0;
        #1;
        chk("byp_count", 1, 32'(out_cnt[1]), 0);
        push_one(1, 8'h07);
        in_pv[1]  = 1'b1;
        in_pd[1]  = 8'h08;
        in_ord[1] = 1'b1;
        #1;
        chk("byp_stored_data", 1, 32'(out_od[1]), 32'h07);
        cyc();
        in_pv[1] = 1'b0;
        #1;
        chk("byp_second_data", 1, 32'(out_od[1]), 32'h08);
        cyc();
        in_ord[1] = 1'b0;

        // Synchronous clear with a pending push.
        push_one(2, 8'h21);
        push_one(2, 8'h22);
        #1;
        chk("srst_pre_count", 2, 32'(out_cnt[2]), 2);
        in_srst[2] = 1'b1;
        in_pv[2]   = 1'b1;
        #1;
        chk("srst_push_ready", 2, 32'(out_prdy[2]), 0);
        chk("srst_pop_valid", 2, 32'(out_ov[2]), 0);
        cyc();
        in_srst[2] = 1'b0;
        in_pv[2]   = 1'b0;
        #1;
        chk("srst_count", 2, 32'(out_cnt[2]), 0);

        // Level flags while filling 0..5.
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("lvl_count", 2, 32'(out_cnt[2]), 32'(i));
            chk("lvl_almost_empty", 2, 32'(out_ae[2]), 32'(ae_tab[i]));
            chk("lvl_almost_full", 2, 32'(out_af[2]), 32'(af_tab[i]));
            if (i < 5) push_one(2, 8'(8'h40 + i));
        end
        chk("lvl_full_push_ready", 2, 32'(out_prdy[2]), 0);

        // Asynchronous reset pulse mid-cycle.
        rst_n = 1'b0;
        #1;
        chk("arst_count", 2, 32'(out_cnt[2]), 0);
        chk("arst_almost_empty", 2, 32'(out_ae[2]), 1);
        #1;
        rst_n = 1'b1;
        cyc();
        #1;
        chk("arst_after_count", 2, 32'(out_cnt[2]), 0);
        chk("arst_after_pop_valid", 2, 32'(out_ov[2]), 0);

        // Random traffic on depth 1 and depth 6.
        for (int c = 0; c < 20000 && !(popped[3] >= 1000 && popped[4] >= 1000); c++) begin
            for (int k = 3; k < 5; k++) begin
                in_pv[k]  = ($urandom_range(0, 99) < 60);
                in_ord[k] = ($urandom_range(0, 99) < 55);
                in_pd[k]  = 8'($urandom_range(0, 255));
            end
            cyc();
        end
        chk("rand_beats_u3", 3, 32'(popped[3] >= 1000), 1);
        chk("rand_beats_u4", 4, 32'(popped[4] >= 1000), 1);
        in_pv[3]  = 1'b0;
        in_pv[4]  = 1'b0;
        in_ord[3] = 1'b1;
        in_ord[4] = 1'b1;
        repeat (10) cyc();
        #1;
        chk("rand_final_count", 3, 32'(out_cnt[3]), 0);
        chk("rand_final_count", 4, 32'(out_cnt[4]), 0);
        chk("rand_final_pop_valid", 3, 32'(out_ov[3]), 0);
        chk("rand_final_pop_valid", 4, 32'(out_ov[4]), 0);
        in_ord = '0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buffer_level.md
BUFFER_LEVEL -- requirements
Module: buffer_level

Interface
REQ-001 SHALL have parameter WIDTH, default 1: payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of storage entries; any value >= 1, not limited to powers of two.
REQ-003 SHALL have parameter SKID, default 0: when 1, push_ready also asserts whenever pop_ready=1.
REQ-004 SHALL have parameter BYPASS, default 0: when 1, an empty buffer passes push data to the pop port in the same cycle.
REQ-005 SHALL have parameter AF_LEVEL, default DEPTH: occupancy at which almost_full asserts.
REQ-006 SHALL have parameter AE_LEVEL, default 0: occupancy at or below which almost_empty asserts.
REQ-007 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port srst, input, 1: synchronous clear, active-high.
REQ-010 SHALL have port push_valid, input, 1: producer offers push_data.
REQ-011 SHALL have port push_ready, output, 1: buffer accepts this cycle.
REQ-012 SHALL have port push_data, input, WIDTH: write payload.
REQ-013 SHALL have port pop_valid, output, 1: pop_data is valid.
REQ-014 SHALL have port pop_ready, input, 1: consumer takes pop_data.
REQ-015 SHALL have port pop_data, output, WIDTH: read payload.
REQ-016 SHALL have port count, output, CW = $clog2(DEPTH+1): current stored-entry count.
REQ-017 SHALL have port almost_full, output, 1: count >= AF_LEVEL.
REQ-018 SHALL have port almost_empty, output, 1: count <= AE_LEVEL.

Function
REQ-019 SHALL treat a push as push_valid & push_ready and a pop as pop_valid & pop_ready, both sampled on the same edge.
REQ-020 SHALL store entries in a circular array; write and read pointers wrap from DEPTH-1 to 0.
REQ-021 SHALL drive push_ready = (count < DEPTH) when SKID=0, and (count < DEPTH) | pop_ready when SKID=1; when full, a simultaneous pop and push are both accepted.
REQ-022 SHALL drive pop_valid = (count != 0) when BYPASS=0; minimum push-to-pop latency is 1 cycle.
REQ-023 SHALL drive pop_valid = (count != 0) | push_valid when BYPASS=1; with count=0, pop_data = push_data combinationally.
REQ-024 SHALL NOT store a bypassed beat (BYPASS=1, count=0, push and pop in the same cycle); pointers and count stay unchanged.
REQ-025 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on both or neither; count never exceeds DEPTH or drops below 0.
REQ-026 SHALL preserve FIFO order; with count>0, pop_data = entry at the read pointer.
REQ-027 SHALL leave pop_data unspecified while pop_valid=0; benches do not check it.
REQ-028 SHALL derive almost_full and almost_empty combinationally from the count register only, with no dependence on the same-cycle handshake.
REQ-029 SHALL, while srst=1, force push_ready=0 and pop_valid=0, and on the edge clear count and both pointers to 0; srst overrides a same-cycle push or pop.
REQ-030 SHALL fail elaboration if DEPTH<1, AF_LEVEL not in 1..DEPTH, AE_LEVEL not in 0..DEPTH-1, or SKID/BYPASS not in {0,1}.

Reset
REQ-031 SHALL, on rst_n low, asynchronously set count=0, both pointers=0, push_ready=1 (SKID irrelevant), pop_valid=0 (BYPASS=1: pop_valid follows push_valid), almost_full=0, almost_empty=1.
REQ-032 SHALL not reset the storage array.
REQ-033 SHALL allow rst_n assertion mid-transfer; any in-flight beat is discarded and the next cycle after release behaves as empty.

Structure
REQ-034 SHALL need no shared-package typedefs; CW and pointer width ($clog2(DEPTH), minimum 1) are local constants.
REQ-035 SHALL be self-contained with no sub-module; pointer wrap increment is a local function.

Verification
REQ-036 SHALL cover: DEPTH=3, BYPASS=0, push 0xA,0xB,0xC, pop_ready=0 -> count=3, push_ready=0, almost_full=1; then pop 3 beats -> 0xA,0xB,0xC in order, count=0.
REQ-037 SHALL cover: DEPTH=3, SKID=1, full, push_valid=1 and pop_ready=1 with 0xD -> push_ready=1, pops 0xA, count stays 3, pointers wrap.
REQ-038 SHALL cover: BYPASS=1, empty, push 0x5 with pop_ready=1 -> pop_valid=1, pop_data=0x5 same cycle, count stays 0.
REQ-039 SHALL cover: DEPTH=5, AF_LEVEL=4, AE_LEVEL=1, fill 0->5 -> almost_empty=1 at counts 0-1, almost_full=1 at counts 4-5.
REQ-040 SHALL cover: count=2, srst=1 with push_valid=1 -> push_ready=0, pop_valid=0, next cycle count=0; rst_n pulse mid-fill -> count=0 immediately.
REQ-041 SHALL cover: random valid/ready (1000 beats, DEPTH=1 and DEPTH=6) against a scoreboard -> no loss, duplication or reorder.
